half_subtractor: RTL and testbench
==================================

# half_subtractor

Single-bit half subtractor computing X − Y as a difference bit D and a borrow-out bit B. The core is purely combinational. A clocked wrapper adds registered copies of the outputs and a saturating borrow-event counter for pipeline integration and on-chip observability. It is a leaf arithmetic cell and the building block for ripple full subtractors.

## Interface
- CNT_W, 8, width of the borrow-event counter (valid range 1..32).
- clk  input  1  rising-edge clock for the registered outputs and counter.
- rst_n  input  1  asynchronous active-low reset.
- X  input  1  minuend.
- Y  input  1  subtrahend.
- D  output  1  combinational difference, X XOR Y.
- B  output  1  combinational borrow, (NOT X) AND Y.
- D_q  output  1  D registered on clk.
- B_q  output  1  B registered on clk.
- clr  input  1  synchronous counter clear, active-high.
- borrow_cnt  output  CNT_W  number of rising clk edges sampled with B = 1, saturating.

One clock; reset is asynchronous and active-low.

## Operation
- Combinational truth table:
  - X=0, Y=0 -> D=0, B=0.
  - X=0, Y=1 -> D=1, B=1.
  - X=1, Y=0 -> D=1, B=0.
  - X=1, Y=1 -> D=0, B=0.
- D and B depend only on X and Y. They ignore clk, rst_n and clr, including during reset.
- Arithmetic identity: X − Y = D − 2·B, for all four input combinations.
- Registered path: on each rising clk edge with rst_n=1, D_q ← D and B_q ← B.
- Counter update, on each rising clk edge with rst_n=1:
  - clr=1 -> borrow_cnt ← 0. Clear has priority over increment when clr and B=1 coincide.
  - clr=0, B=1, borrow_cnt < 2^CNT_W − 1 -> increment by 1.
  - clr=0, B=1, borrow_cnt = 2^CNT_W − 1 -> hold (saturate, no wrap).
  - clr=0, B=0 -> hold.
- X, Y and clr are synchronous to clk for the registered path. Unknown (X/Z) inputs propagate to D/B; no masking.

## Timing
- D, B: zero-cycle combinational latency, with no internal state.
- D_q, B_q: one-cycle latency. They reflect X/Y sampled at the most recent rising edge.
- borrow_cnt: updates at the rising edge that samples B=1. The new value is visible after that edge.
- Reset: rst_n=0 forces D_q=0, B_q=0 and borrow_cnt=0 immediately, without waiting for clk. All three hold while rst_n=0.
- Reset release: the first rising edge with rst_n=1 resumes normal updates.
- Reset asserted mid-operation: counter contents are lost. There is no recovery of the pre-reset count.
- Reset affects only the registered outputs; D/B remain live throughout.
- Counter saturation: after reaching 2^CNT_W − 1, only clr or rst_n returns it to 0.

## Test plan
- Exhaustive combinational sweep: apply X,Y = 00, 01, 10, 11 at 10-time-unit spacing with no clock. Required D,B = 0,0 / 1,1 / 1,0 / 0,0, each visible in the same time step as the input change.
- Registered latency: hold rst_n=1 and apply X=0,Y=1 before edge n. Required D_q=1, B_q=1 after edge n. Then apply X=1,Y=1, and D_q=0, B_q=0 are required after edge n+1.
- Asynchronous reset: with borrow_cnt=5 and D_q=1, drop rst_n between edges. Required D_q=0, B_q=0 and borrow_cnt=0 immediately, while D/B continue to track X/Y.
- Counter and clear priority: hold X=0,Y=1 for 3 edges, giving borrow_cnt=3. Then assert clr=1 with B=1 for one edge; borrow_cnt=0 is required.
- Saturation: with CNT_W=2, hold B=1 for 6 edges. Required borrow_cnt sequence is 1, 2, 3, 3, 3, 3.
- Identity check: for every X,Y combination, require X − Y == D − 2·B.

Source files
------------

// File: rtl/half_subtractor.sv
// Single-bit half subtractor (X - Y -> D, B) with registered
// copies of the outputs and a saturating borrow-event counter.
module half_subtractor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             X,
  input  logic             Y,
  input  logic             clr,
  output logic             D,
  output logic             B,
  output logic             D_q,
  output logic             B_q,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_d;
  logic             w_b;
  logic             w_cnt_sat;
  logic             r_d;
  logic             r_b;
  logic [CNT_W-1:0] r_cnt;

  // Combinational core; X/Z on the inputs propagates unmasked.
  assign w_d = X ^ Y;
  assign w_b = ~X & Y;

  assign w_cnt_sat = (r_cnt == CNT_MAX);

  // Registered copies of the difference and borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= 1'b0;
      r_b <= 1'b0;
    end else begin
      r_d <= w_d;
      r_b <= w_b;
    end
  end

  // Borrow-event counter: clear wins, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_b && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign D          = w_d;
  assign B          = w_b;
  assign D_q        = r_d;
  assign B_q        = r_b;
  assign borrow_cnt = r_cnt;

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor: an 8-bit and a
// 2-bit counter instance driven by the same stimulus.
module tb_half_subtractor;

  typedef struct {
    logic       dq;
    logic       bq;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       X;
  logic       Y;
  logic       clr;
  logic       D8, B8, Dq8, Bq8;
  logic       D2, B2, Dq2, Bq2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  half_subtractor #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .clr(clr),
    .D(D8), .B(B8), .D_q(Dq8), .B_q(Bq8),
    .borrow_cnt(cnt8)
  );

  half_subtractor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .clr(clr),
    .D(D2), .B(B2), .D_q(Dq2), .B_q(Bq2),
    .borrow_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Combinational outputs of both instances plus the identity.
  task automatic chk_comb(input logic ed, input logic eb);
    int lhs;
    int rhs;
    chk("D8", {7'd0, D8}, {7'd0, ed});
    chk("B8", {7'd0, B8}, {7'd0, eb});
    chk("D2", {7'd0, D2}, {7'd0, ed});
    chk("B2", {7'd0, B2}, {7'd0, eb});
    lhs = int'(X) - int'(Y);
    rhs = int'(D8) - 2 * int'(B8);
    chk("identity", 8'(lhs), 8'(rhs));
  endtask

  task automatic chk_regs_zero(input string nm);
    chk({nm, "_Dq8"}, {7'd0, Dq8}, 8'd0);
    chk({nm, "_Bq8"}, {7'd0, Bq8}, 8'd0);
    chk({nm, "_cnt8"}, cnt8, 8'd0);
    chk({nm, "_Dq2"}, {7'd0, Dq2}, 8'd0);
    chk({nm, "_Bq2"}, {7'd0, Bq2}, 8'd0);
    chk({nm, "_cnt2"}, {6'd0, cnt2}, 8'd0);
  endtask

  // One clocked vector; expectation holds after the next edge.
  task automatic step(input logic x, input logic y,
                      input logic c,
                      input logic edq, input logic ebq,
                      input logic [7:0] ec8,
                      input logic [1:0] ec2);
    exp_t e;
    @(negedge clk);
    #1;
    X   = x;
    Y   = y;
    clr = c;
    e.dq = edq;
    e.bq = ebq;
    e.c8 = ec8;
    e.c2 = ec2;
    sb.push_back(e);
  endtask

  // Monitor: registered outputs are valid at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Dq8", {7'd0, Dq8}, {7'd0, e.dq});
      chk("Bq8", {7'd0, Bq8}, {7'd0, e.bq});
      chk("cnt8", cnt8, e.c8);
      chk("Dq2", {7'd0, Dq2}, {7'd0, e.dq});
      chk("Bq2", {7'd0, Bq2}, {7'd0, e.bq});
      chk("cnt2", {6'd0, cnt2}, {6'd0, e.c2});
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    X     = 1'b0;
    Y     = 1'b0;
    clr   = 1'b0;
    #2;
    chk_regs_zero("rst");

    // Sweep under reset: core stays live, registers stay 0.
    X = 0; Y = 0; #1; chk_comb(1'b0, 1'b0); #9;
    X = 0; Y = 1; #1; chk_comb(1'b1, 1'b1); #9;
    X = 1; Y = 0; #1; chk_comb(1'b1, 1'b0); #9;
    X = 1; Y = 1; #1; chk_comb(1'b0, 1'b0); #9;
    chk_regs_zero("rsthold");

    X = 0; Y = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Latency: 01 then 11.
    step(0, 1, 0, 1, 1, 8'd1, 2'd1);
    step(1, 1, 0, 0, 0, 8'd1, 2'd1);
    // Clear beats a coincident borrow.
    step(0, 1, 1, 1, 1, 8'd0, 2'd0);
    // Six borrow edges: 2-bit counter saturates at 3.
    step(0, 1, 0, 1, 1, 8'd1, 2'd1);
    step(0, 1, 0, 1, 1, 8'd2, 2'd2);
    step(0, 1, 0, 1, 1, 8'd3, 2'd3);
    step(0, 1, 0, 1, 1, 8'd4, 2'd3);
    step(0, 1, 0, 1, 1, 8'd5, 2'd3);
    step(0, 1, 0, 1, 1, 8'd6, 2'd3);
    // No borrow: hold.
    step(1, 0, 0, 1, 0, 8'd6, 2'd3);
    step(0, 0, 0, 0, 0, 8'd6, 2'd3);
    // Clear from saturation, then count to 3.
    step(0, 1, 1, 1, 1, 8'd0, 2'd0);
    step(0, 1, 0, 1, 1, 8'd1, 2'd1);
    step(0, 1, 0, 1, 1, 8'd2, 2'd2);
    step(0, 1, 0, 1, 1, 8'd3, 2'd3);
    step(1, 1, 1, 0, 0, 8'd0, 2'd0);
    // Build count 5 with D_q=1 ahead of async reset.
    step(0, 1, 0, 1, 1, 8'd1, 2'd1);
    step(0, 1, 0, 1, 1, 8'd2, 2'd2);
    step(0, 1, 0, 1, 1, 8'd3, 2'd3);
    step(0, 1, 0, 1, 1, 8'd4, 2'd3);
    step(0, 1, 0, 1, 1, 8'd5, 2'd3);
    drain();

    // Async reset between edges.
    #2;
    chk("pre_cnt8", cnt8, 8'd5);
    rst_n = 1'b0;
    #1;
    chk_regs_zero("arst");
    chk_comb(1'b1, 1'b1);
    X = 1; Y = 0;
    #1;
    chk_comb(1'b1, 1'b0);
    X = 0; Y = 1;
    @(posedge clk);
    #1;
    chk_regs_zero("arsthold");

    // Resume after release.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 1, 0, 1, 1, 8'd2, 2'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
